pipeline_control: RTL
=====================

PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have parameter RAW, default 5, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, event-counter width.
REQ-003 SHALL have parameter INTERLOCK, default 1; 1 = load-use stall enabled, 0 = no stall (software-scheduled).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high.
REQ-006 SHALL have port OpCode  input  6  opcode of instruction in ID.
REQ-007 SHALL have port id_valid  input  1  ID holds a real instruction.
REQ-008 SHALL have ports rs, rt, rd  input  RAW each  register fields of the ID instruction.
REQ-009 SHALL have port ex_zero  input  1  ALU zero flag from EX.
REQ-010 SHALL have ports ex_RegDst, ex_ALUSrc  output  1 each  EX-stage controls.
REQ-011 SHALL have port ex_ALUOp  output  2  EX-stage ALUOp {ALUOp1,ALUOp0}.
REQ-012 SHALL have ports mem_MemRead, mem_MemWrite, mem_Branch  output  1 each  MEM-stage controls.
REQ-013 SHALL have ports wb_RegWrite, wb_MemtoReg  output  1 each; wb_dest  output  RAW  WB destination.
REQ-014 SHALL have ports stall, flush  output  1 each  (hold PC and IF/ID; clear IF/ID).
REQ-015 SHALL have port illegal_op  output  1  registered one-cycle pulse.
REQ-016 SHALL have ports stall_cnt, flush_cnt  output  CNT_W each  event counters.

Function
REQ-017 SHALL decode, as {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp}:
- 000000 R-type: 1,0,0,1,0,0,0,10
- 100011 lw: 0,1,1,1,1,0,0,00
- 101011 sw: 0,1,0,0,0,1,0,00
- 000100 beq: 0,0,0,0,0,0,1,01
- 001000 addi: 0,1,0,1,0,0,0,00
- any other opcode, or id_valid=0: all zero (bubble).
REQ-018 SHALL register decoded controls into three stage registers ID/EX, EX/MEM, MEM/WB; each control appears at its stage output one, two or three cycles after the ID cycle.
REQ-019 SHALL compute destination = rd when RegDst=1, else rt; it travels with the instruction to wb_dest.
REQ-020 SHALL capture ex_zero into EX/MEM as mem_zero.
REQ-021 SHALL drive flush = mem_Branch & mem_zero, combinationally.
REQ-022 SHALL, when INTERLOCK=1, drive stall = id_valid & ex_MemRead & ex_dest!=0 & (ex_dest==rs | (ex_dest==rt & OpCode in {R-type, sw, beq})); stall SHALL be 0 when INTERLOCK=0.
REQ-023 SHALL, on stall, load a bubble into ID/EX; EX/MEM and MEM/WB advance normally.
REQ-024 SHALL, on flush, load bubbles into ID/EX and EX/MEM; MEM/WB advances normally.
REQ-025 SHALL force stall=0 whenever flush=1; flush takes priority.
REQ-026 SHALL pulse illegal_op one cycle after an ID cycle with id_valid=1, no stall, no flush, and an opcode not in REQ-017.
REQ-027 SHALL increment stall_cnt each cycle stall=1 and flush_cnt each cycle flush=1; both SHALL saturate at all-ones and never wrap.

Reset
REQ-028 SHALL, on a clock edge with reset=1, clear all stage registers, mem_zero, illegal_op and both counters to 0; all control outputs, wb_dest, stall and flush then read 0.
REQ-029 SHALL give reset priority over stall, flush and counting, including reset asserted mid-stall or mid-flush.

Verification
REQ-030 SHALL pass: R-type (rd=3) then idle -> ex_RegDst=1, ex_ALUOp=10 at +1; wb_RegWrite=1, wb_dest=3 at +3.
REQ-031 SHALL pass: lw rt=4, then add rs=4 -> stall=1 for one cycle, one bubble in EX, stall_cnt=1; with INTERLOCK=0 -> stall=0.
REQ-032 SHALL pass: lw rt=0, then add rs=0 -> stall=0.
REQ-033 SHALL pass: beq with ex_zero=1 in its EX cycle -> flush=1 one cycle later; the next two younger instructions reach MEM/WB as all-zero; flush_cnt=1.
REQ-034 SHALL pass: beq taken while a load-use stall condition is present -> flush=1, stall=0; opcode 111111 -> illegal_op=1 for exactly one cycle.
REQ-035 SHALL pass: CNT_W=2 with five stall cycles -> stall_cnt=3; reset asserted during a stall -> all outputs 0 on the following cycle.

Source files
------------

// File: rtl/pipeline_control.sv
// Control path for a classic 5-stage pipeline: main decode, ID/EX -> EX/MEM -> MEM/WB
// control registers, load-use interlock, branch flush and saturating event counters.
module pipeline_control #(
  parameter int RAW       = 5,
  parameter int CNT_W     = 16,
  parameter int INTERLOCK = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OpCode,
  input  logic             id_valid,
  input  logic [RAW-1:0]   rs,
  input  logic [RAW-1:0]   rt,
  input  logic [RAW-1:0]   rd,
  input  logic             ex_zero,
  output logic             ex_RegDst,
  output logic             ex_ALUSrc,
  output logic [1:0]       ex_ALUOp,
  output logic             mem_MemRead,
  output logic             mem_MemWrite,
  output logic             mem_Branch,
  output logic             wb_RegWrite,
  output logic             wb_MemtoReg,
  output logic [RAW-1:0]   wb_dest,
  output logic             stall,
  output logic             flush,
  output logic             illegal_op,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic zero;
  } mem_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_t;

  ctrl_t            id_ctrl;
  logic             id_legal;
  logic             rt_used;
  logic [RAW-1:0]   id_dest;
  logic             hazard;

  ctrl_t            ex_q, ex_d;
  logic [RAW-1:0]   ex_dest_q, ex_dest_d;
  mem_t             mem_q, mem_d;
  logic [RAW-1:0]   mem_dest_q, mem_dest_d;
  wb_t              wb_q, wb_d;
  logic [RAW-1:0]   wb_dest_q, wb_dest_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // ID: decode; an invalid slot decodes as a bubble
  always_comb begin
    id_ctrl  = '0;
    id_legal = 1'b1;
    case (OpCode)
      OP_R:    id_ctrl = ctrl_t'(9'b1_0_0_1_0_0_0_10);
      OP_LW:   id_ctrl = ctrl_t'(9'b0_1_1_1_1_0_0_00);
      OP_SW:   id_ctrl = ctrl_t'(9'b0_1_0_0_0_1_0_00);
      OP_BEQ:  id_ctrl = ctrl_t'(9'b0_0_0_0_0_0_1_01);
      OP_ADDI: id_ctrl = ctrl_t'(9'b0_1_0_1_0_0_0_00);
      default: id_legal = 1'b0;
    endcase
    if (!id_valid) id_ctrl = '0;
  end

  assign rt_used = (OpCode == OP_R) || (OpCode == OP_SW) || (OpCode == OP_BEQ);
  assign id_dest = id_ctrl.reg_dst ? rd : rt;

  // rt only counts as a source for opcodes that actually read it
  assign hazard = (INTERLOCK != 0) && id_valid && ex_q.mem_read && (ex_dest_q != '0) &&
                  ((ex_dest_q == rs) || ((ex_dest_q == rt) && rt_used));
  assign flush  = mem_q.branch & mem_q.zero;
  assign stall  = hazard & ~flush;

  always_comb begin
    ex_d       = (stall || flush) ? '0 : id_ctrl;
    ex_dest_d  = (stall || flush) ? '0 : id_dest;
    mem_d      = '0;
    mem_dest_d = '0;
    if (!flush) begin
      mem_d.mem_to_reg = ex_q.mem_to_reg;
      mem_d.reg_write  = ex_q.reg_write;
      mem_d.mem_read   = ex_q.mem_read;
      mem_d.mem_write  = ex_q.mem_write;
      mem_d.branch     = ex_q.branch;
      mem_d.zero       = ex_zero;
      mem_dest_d       = ex_dest_q;
    end
    wb_d.mem_to_reg = mem_q.mem_to_reg;
    wb_d.reg_write  = mem_q.reg_write;
    wb_dest_d       = mem_dest_q;
    illegal_d       = id_valid & ~id_legal & ~stall & ~flush;
    stall_cnt_d     = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d     = (flush && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  // ID/EX, EX/MEM, MEM/WB boundaries
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      ex_dest_q   <= '0;
      mem_q       <= '0;
      mem_dest_q  <= '0;
      wb_q        <= '0;
      wb_dest_q   <= '0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      ex_dest_q   <= ex_dest_d;
      mem_q       <= mem_d;
      mem_dest_q  <= mem_dest_d;
      wb_q        <= wb_d;
      wb_dest_q   <= wb_dest_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_RegDst    = ex_q.reg_dst;
  assign ex_ALUSrc    = ex_q.alu_src;
  assign ex_ALUOp     = ex_q.alu_op;
  assign mem_MemRead  = mem_q.mem_read;
  assign mem_MemWrite = mem_q.mem_write;
  assign mem_Branch   = mem_q.branch;
  assign wb_RegWrite  = wb_q.reg_write;
  assign wb_MemtoReg  = wb_q.mem_to_reg;
  assign wb_dest      = wb_dest_q;
  assign illegal_op   = illegal_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule
